// File: rtl/seq_mult_param_if.sv
// Start/busy/done handshake bundle for the sequential multiplier.
// The requester drives the operands; the multiplier returns the product.
interface seq_mult_param_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic                 done;

    modport master (
        output start, signed_mode, A, B,
        input  product, busy, done
    );

    modport slave (
        input  start, signed_mode, A, B,
        output product, busy, done
    );
endinterface

// File: rtl/seq_mult_param.sv
// Parametrised shift-add multiplier: one add-and-shift per clock,
// sign handled by multiplying magnitudes and negating the result once.
module seq_mult_param #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    seq_mult_param_if.slave  bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [CW-1:0]        count;
    logic [2*WIDTH:0]     acc;
    logic [WIDTH-1:0]     mag_b;
    logic                 neg;
    logic [WIDTH-1:0]     mag_a_in;
    logic [WIDTH-1:0]     mag_b_in;
    logic [WIDTH:0]       hi;
    logic [2*WIDTH-1:0]   product;
    logic                 done;

    // The most negative value maps to 2^(WIDTH-1), still fits unsigned.
    assign mag_a_in = (bus.signed_mode && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign mag_b_in = (bus.signed_mode && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    assign hi = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mag_b} : '0);

    assign bus.product = product;
    assign bus.done    = done;
    assign bus.busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.start) state_n = RUN;
            RUN:     if (count == LAST) state_n = FIX;
            FIX:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count   <= '0;
            acc     <= '0;
            mag_b   <= '0;
            neg     <= 1'b0;
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        neg   <= bus.signed_mode & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        mag_b <= mag_b_in;
                        acc   <= {{(WIDTH+1){1'b0}}, mag_a_in};
                        count <= '0;
                    end
                end
                RUN: begin
                    acc   <= {1'b0, hi, acc[WIDTH-1:1]};
                    count <= count + CW'(1);
                end
                FIX: begin
                    product <= neg ? -acc[2*WIDTH-1:0] : acc[2*WIDTH-1:0];
                    done    <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench: three widths, directed vectors plus random sweeps.
// Expected products are queued on issue and popped on each done pulse.
module tb_seq_mult_param;
    logic clk;
    logic reset;

    seq_mult_param_if #(.WIDTH(4))  bus4 ();
    seq_mult_param_if #(.WIDTH(8))  bus8 ();
    seq_mult_param_if #(.WIDTH(16)) bus16 ();

    seq_mult_param #(.WIDTH(4))  u4  (.clk(clk), .reset(reset), .bus(bus4));
    seq_mult_param #(.WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(bus8));
    seq_mult_param #(.WIDTH(16)) u16 (.clk(clk), .reset(reset), .bus(bus16));

    int checks;
    int failures;
    longint unsigned q4[$];
    longint unsigned q8[$];
    longint unsigned q16[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, longint got, longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    function automatic longint unsigned model(int w, longint unsigned a,
                                              longint unsigned b, bit sm);
        longint sa;
        longint sb;
        longint p;
        sa = longint'(a);
        sb = longint'(b);
        if (sm && a[w-1]) sa = sa - (longint'(1) << w);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return longint'(p) & ((longint'(1) << (2*w)) - 1);
    endfunction

    // Scoreboard monitors
    always @(negedge clk) begin
        if (bus4.done) begin
            if (q4.size() == 0) chk("w4_unexpected_done", 1, 0);
            else chk("w4_product", longint'(bus4.product), longint'(q4.pop_front()));
        end
        if (bus8.done) begin
            if (q8.size() == 0) chk("w8_unexpected_done", 1, 0);
            else chk("w8_product", longint'(bus8.product), longint'(q8.pop_front()));
        end
        if (bus16.done) begin
            if (q16.size() == 0) chk("w16_unexpected_done", 1, 0);
            else chk("w16_product", longint'(bus16.product), longint'(q16.pop_front()));
        end
    end

    // Counts edges until done is seen; -1 on timeout.
    task automatic wait_done(input int w, output int n);
        logic d;
        n = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            d = (w == 4) ? bus4.done : (w == 8) ? bus8.done : bus16.done;
            if (d) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic sm);
        @(posedge clk);
        #1;
        bus4.start = 1'b1;
        bus4.A = a;
        bus4.B = b;
        bus4.signed_mode = sm;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        bus4.A = ~a;
        bus4.B = ~b;
        bus4.signed_mode = ~sm;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                       input logic [7:0] exp, input string name);
        int n;
        q4.push_back(longint'(exp));
        start4(a, b, sm);
        wait_done(4, n);
        chk(name, n, 5);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm);
        int n;
        q8.push_back(model(8, longint'(a), longint'(b), sm));
        @(posedge clk);
        #1;
        bus8.start = 1'b1;
        bus8.A = a;
        bus8.B = b;
        bus8.signed_mode = sm;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        bus8.A = ~a;
        wait_done(8, n);
        chk("w8_latency", n, 9);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic sm);
        int n;
        q16.push_back(model(16, longint'(a), longint'(b), sm));
        @(posedge clk);
        #1;
        bus16.start = 1'b1;
        bus16.A = a;
        bus16.B = b;
        bus16.signed_mode = sm;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        bus16.B = ~b;
        wait_done(16, n);
        chk("w16_latency", n, 17);
    endtask

    initial begin
        int n;
        logic [15:0] corner [5];
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus4.start = 0;  bus4.signed_mode = 0;  bus4.A = 0;  bus4.B = 0;
        bus8.start = 0;  bus8.signed_mode = 0;  bus8.A = 0;  bus8.B = 0;
        bus16.start = 0; bus16.signed_mode = 0; bus16.A = 0; bus16.B = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_busy", bus4.busy, 0);
        chk("reset_done", bus4.done, 0);
        chk("reset_product", bus4.product, 0);

        // Directed width-4 vectors
        op4(4'hF, 4'hF, 1'b0, 8'hE1, "lat_15x15");
        op4(4'h8, 4'h8, 1'b1, 8'h40, "lat_m8xm8");
        op4(4'hD, 4'h5, 1'b1, 8'hF1, "lat_m3x5");
        op4(4'h7, 4'hF, 1'b1, 8'hF9, "lat_7xm1");
        op4(4'hD, 4'h5, 1'b0, 8'h41, "lat_13x5u");
        op4(4'h0, 4'h9, 1'b0, 8'h00, "lat_0x9");
        chk("held_product", bus4.product, 0);

        // Start while busy is ignored; start in the done cycle is accepted
        q4.push_back(64'h0F);
        start4(4'h3, 4'h5, 1'b0);
        @(posedge clk);
        #1;
        chk("busy_in_run", bus4.busy, 1);
        bus4.start = 1'b1;
        bus4.A = 4'h2;
        bus4.B = 4'h2;
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        wait_done(4, n);
        chk("ignored_start_lat", n, 3);
        bus4.start = 1'b1;
        bus4.A = 4'h6;
        bus4.B = 4'h7;
        bus4.signed_mode = 1'b0;
        q4.push_back(64'h2A);
        @(posedge clk);
        #1;
        bus4.start = 1'b0;
        chk("done_falls", bus4.done, 0);
        wait_done(4, n);
        chk("b2b_lat", n, 5);

        // Reset in RUN at count=2 abandons the operation
        q4.push_back(64'h51);
        start4(4'h9, 4'h9, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        q4.delete();
        chk("abort_busy", bus4.busy, 0);
        chk("abort_done", bus4.done, 0);
        chk("abort_product", bus4.product, 0);
        repeat (10) @(posedge clk);
        op4(4'h2, 4'h3, 1'b0, 8'h06, "after_abort");

        // Corner operands at widths 8 and 16
        corner[0] = 16'h0000;
        corner[1] = 16'h0001;
        corner[2] = 16'hFFFF;
        corner[3] = 16'h7FFF;
        corner[4] = 16'h8000;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++) begin
                    op8({corner[i][15], corner[i][6:0]},
                        {corner[j][15], corner[j][6:0]}, m[0]);
                    op16(corner[i], corner[j], m[0]);
                end

        for (int k = 0; k < 1000; k++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom));
            op16(16'($urandom), 16'($urandom), 1'($urandom));
        end

        repeat (3) @(posedge clk);
        chk("q4_drained", q4.size(), 0);
        chk("q8_drained", q8.size(), 0);
        chk("q16_drained", q16.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
